// File: rtl/bit_to_symbol_mapper_pkg.sv
// Shared modem header: bits-per-symbol for each supported constellation.
// Imported by the symbol mapper and available to the rest of the modulator.
package bit_to_symbol_mapper_pkg;

  localparam int unsigned MOD_QPSK   = 2;
  localparam int unsigned MOD_8PSK   = 3;
  localparam int unsigned MOD_16APSK = 4;
  localparam int unsigned MOD_32APSK = 5;

endpackage

// File: rtl/bit_to_symbol_mapper.sv
// bit_to_symbol_mapper
//   Repacks an AXI-Stream of INPUT_WIDTH-bit payload words into
//   SYMBOL_WIDTH-bit constellation indices, MSB first, zero-extended to
//   ADDRESS_WIDTH for the symbol lookup table. Bits carry across word
//   boundaries; a frame that does not end on a symbol boundary ends with a
//   zero-padded symbol carrying tlast. Frames never merge.
//
// Ports
//   data_in_aclk     clock, rising edge
//   data_in_aresetn  synchronous active-low reset
//   data_in_*        input stream (tdata bit INPUT_WIDTH-1 sent first)
//   data_out_*       registered output stream of symbol indices
module bit_to_symbol_mapper
  import bit_to_symbol_mapper_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH   = 8,
  parameter int unsigned SYMBOL_WIDTH  = MOD_QPSK,
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic                     data_in_aclk,
  input  logic                     data_in_aresetn,
  output logic                     data_in_tready,
  input  logic [INPUT_WIDTH-1:0]   data_in_tdata,
  input  logic                     data_in_tlast,
  input  logic                     data_in_tvalid,
  input  logic                     data_out_tready,
  output logic [ADDRESS_WIDTH-1:0] data_out_tdata,
  output logic                     data_out_tlast,
  output logic                     data_out_tvalid
);

  localparam int unsigned BUF_W = INPUT_WIDTH + SYMBOL_WIDTH - 1;
  localparam int unsigned EXT_W = BUF_W + SYMBOL_WIDTH;
  localparam int unsigned CNT_W = $clog2(INPUT_WIDTH + 2 * SYMBOL_WIDTH + 1);

  localparam logic [CNT_W-1:0] SW_C  = CNT_W'(SYMBOL_WIDTH);
  localparam logic [CNT_W-1:0] SW2_C = CNT_W'(2 * SYMBOL_WIDTH);
  localparam logic [CNT_W-1:0] IW_C  = CNT_W'(INPUT_WIDTH);

  logic [BUF_W-1:0]         bit_buf_q, bit_buf_d;
  logic [CNT_W-1:0]         bit_count_q, bit_count_d;
  logic                     last_pending_q, last_pending_d;
  logic [ADDRESS_WIDTH-1:0] out_tdata_q, out_tdata_d;
  logic                     out_tlast_q, out_tlast_d;
  logic                     out_tvalid_q, out_tvalid_d;

  logic                     out_free;
  logic                     extract;
  logic                     accept;
  logic                     final_sym;
  logic [CNT_W-1:0]         take;
  logic [CNT_W-1:0]         remaining;
  logic [EXT_W-1:0]         buf_ext;
  logic [SYMBOL_WIDTH-1:0]  symbol;

  assign out_free  = !out_tvalid_q || data_out_tready;
  assign extract   = out_free &&
                     ((bit_count_q >= SW_C) || (last_pending_q && (bit_count_q != '0)));
  assign final_sym = last_pending_q && (bit_count_q <= SW_C);

  // Accept a word only when the survivors of this cycle's extract are fewer
  // than one symbol, so the buffer never exceeds INPUT_WIDTH+SYMBOL_WIDTH-1.
  assign data_in_tready = data_in_aresetn && !last_pending_q &&
                          ((bit_count_q < SW_C) || (extract && (bit_count_q < SW2_C)));
  assign accept         = data_in_tvalid && data_in_tready;

  always_comb begin
    take      = (bit_count_q < SW_C) ? bit_count_q : SW_C;
    remaining = extract ? (bit_count_q - take) : bit_count_q;

    // Appending SYMBOL_WIDTH zeros below the buffer makes one shift serve both
    // the full-symbol case and the zero-padded tail: the window
    // [bit_count-1 -: SYMBOL_WIDTH] of the buffer lands in the low bits.
    buf_ext = {bit_buf_q, {SYMBOL_WIDTH{1'b0}}};
    symbol  = SYMBOL_WIDTH'(buf_ext >> bit_count_q);

    bit_buf_d      = bit_buf_q;
    bit_count_d    = remaining;
    last_pending_d = last_pending_q;
    out_tdata_d    = out_tdata_q;
    out_tlast_d    = out_tlast_q;
    out_tvalid_d   = out_tvalid_q;

    // Surviving bits sit in the low end of the buffer; the new word goes
    // underneath them. Stale bits above bit_count are never read.
    if (accept) begin
      bit_buf_d   = (bit_buf_q << INPUT_WIDTH) | BUF_W'(data_in_tdata);
      bit_count_d = remaining + IW_C;
    end

    if (extract) begin
      out_tdata_d  = ADDRESS_WIDTH'(symbol);
      out_tlast_d  = final_sym;
      out_tvalid_d = 1'b1;
    end else if (data_out_tready) begin
      out_tvalid_d = 1'b0;
    end

    if (accept && data_in_tlast) begin
      last_pending_d = 1'b1;
    end else if (extract && final_sym) begin
      last_pending_d = 1'b0;
    end
  end

  always_ff @(posedge data_in_aclk) begin
    if (!data_in_aresetn) begin
      bit_buf_q      <= '0;
      bit_count_q    <= '0;
      last_pending_q <= 1'b0;
      out_tdata_q    <= '0;
      out_tlast_q    <= 1'b0;
      out_tvalid_q   <= 1'b0;
    end else begin
      bit_buf_q      <= bit_buf_d;
      bit_count_q    <= bit_count_d;
      last_pending_q <= last_pending_d;
      out_tdata_q    <= out_tdata_d;
      out_tlast_q    <= out_tlast_d;
      out_tvalid_q   <= out_tvalid_d;
    end
  end

  assign data_out_tdata  = out_tdata_q;
  assign data_out_tlast  = out_tlast_q;
  assign data_out_tvalid = out_tvalid_q;

endmodule

// File: tb/tb_bit_to_symbol_mapper.sv
// Self-checking bench for bit_to_symbol_mapper. Two instances share the clock
// and reset: index 0 uses 2-bit symbols, index 1 uses 3-bit symbols.
module tb_bit_to_symbol_mapper;

  logic            clk;
  logic            rst_n;
  logic [1:0]      in_valid;
  logic [1:0]      in_last;
  logic [1:0][7:0] in_data;
  logic [1:0]      in_tready;
  logic [1:0]      out_ready;
  logic [1:0]      out_valid;
  logic [1:0]      out_last;
  logic [1:0][7:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int bad_spacing = 0;
  bit chk_spacing = 0;
  bit rand_rdy    = 0;

  // expected symbols: {tlast, index}
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    int         hs_cnt;
    int         run_len;
    logic       hs_prev;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;

    bit_to_symbol_mapper #(
      .INPUT_WIDTH  (8),
      .SYMBOL_WIDTH ((g == 0) ? 2 : 3),
      .ADDRESS_WIDTH(8)
    ) u_dut (
      .data_in_aclk   (clk),
      .data_in_aresetn(rst_n),
      .data_in_tready (in_tready[g]),
      .data_in_tdata  (in_data[g]),
      .data_in_tlast  (in_last[g]),
      .data_in_tvalid (in_valid[g]),
      .data_out_tready(out_ready[g]),
      .data_out_tdata (out_data[g]),
      .data_out_tlast (out_last[g]),
      .data_out_tvalid(out_valid[g])
    );

    initial begin
      hs_cnt  = 0;
      run_len = 0;
    end

    always @(negedge clk) begin
      logic [8:0] e;
      bit         ok;
      if (rst_n) begin
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid[g]), 32'd1);
          check("stall_data", 32'(out_data[g]), 32'(prev_data));
          check("stall_last", 32'(out_last[g]), 32'(prev_last));
        end
        if (out_valid[g] && out_ready[g]) begin
          pop_exp(g, e, ok);
          if (ok) begin
            check("sym_data", 32'(out_data[g]), 32'(e[7:0]));
            check("sym_last", 32'(out_last[g]), 32'(e[8]));
          end else begin
            check("unexpected_sym", 32'(out_valid[g]), 32'd0);
          end
          hs_cnt  <= hs_cnt + 1;
          run_len <= hs_prev ? run_len + 1 : 1;
        end
        hs_prev    <= out_valid[g] && out_ready[g];
        prev_stall <= out_valid[g] && !out_ready[g];
        prev_data  <= out_data[g];
        prev_last  <= out_last[g];
      end else begin
        hs_prev    <= 1'b0;
        prev_stall <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void pop_exp(input int d, output logic [8:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    if (d == 0 && exp_q0.size() > 0) begin v = exp_q0.pop_front(); ok = 1'b1; end
    if (d == 1 && exp_q1.size() > 0) begin v = exp_q1.pop_front(); ok = 1'b1; end
  endfunction

  function automatic int exp_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Reference: flatten the frame to a bit list MSB first, pad with zeros to
  // a whole number of symbols, cut into symbols; the final one carries tlast.
  function automatic void model_frame(input int d, input logic [7:0] bytes[$]);
    int         sw;
    int         nsym;
    bit         bits[$];
    logic [7:0] b;
    logic [7:0] val;
    sw = (d == 0) ? 2 : 3;
    foreach (bytes[i]) begin
      b = bytes[i];
      for (int k = 7; k >= 0; k--) bits.push_back(b[k]);
    end
    nsym = (bits.size() + sw - 1) / sw;
    for (int s = 0; s < nsym; s++) begin
      val = '0;
      for (int k = 0; k < sw; k++) begin
        val = val << 1;
        if (s * sw + k < bits.size()) val[0] = bits[s * sw + k];
      end
      if (d == 0) exp_q0.push_back({(s == nsym - 1), val});
      else        exp_q1.push_back({(s == nsym - 1), val});
    end
  endfunction

  task automatic send_frame(input int d, input logic [7:0] bytes[$]);
    bit acc;
    int prev_acc;
    model_frame(d, bytes);
    prev_acc = -1;
    foreach (bytes[i]) begin
      @(posedge clk); #1;
      in_valid[d] = 1'b1;
      in_data[d]  = bytes[i];
      in_last[d]  = (i == bytes.size() - 1);
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge clk);
        if (in_tready[d]) acc = 1'b1;
      end
      if (!acc) begin
        check("accept_timeout", 32'(in_tready[d]), 32'd1);
        break;
      end
      if (chk_spacing && prev_acc >= 0 && (cyc - prev_acc) != 4) bad_spacing++;
      prev_acc = cyc;
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 5000 && !done; t++) begin
      @(negedge clk); #1;
      if (exp_size(d) == 0 && !out_valid[d]) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'(exp_size(d)), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    int         base;
    bit         seen;

    rst_n     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 2'b11;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", 32'(out_valid[d]), 32'd0);
      check("rst_last", 32'(out_last[d]), 32'd0);
      check("rst_data", 32'(out_data[d]), 32'd0);
      check("rst_in_tready", 32'(in_tready[d]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_tready0", 32'(in_tready[0]), 32'd1);

    // QPSK single byte: 2,3,1,0 with one-cycle latency after the accept edge
    fr = {8'hB4};
    send_frame(0, fr);
    @(negedge clk);
    check("lat_not_yet", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    check("lat_first", 32'(out_valid[0]), 32'd1);
    wait_drain(0);

    // 8PSK two words: 5,5,0,5,5,0(pad, tlast)
    fr = {8'hB4, 8'h5A};
    send_frame(1, fr);
    wait_drain(1);

    // 8PSK single word: input stays blocked until the padded tlast symbol
    fr = {8'hB4};
    send_frame(1, fr);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (out_valid[1] && out_last[1]) seen = 1'b1;
      else check("tready_hold", 32'(in_tready[1]), 32'd0);
    end
    check("tlast_seen", 32'(seen), 32'd1);
    check("tready_release", 32'(in_tready[1]), 32'd1);
    wait_drain(1);

    // QPSK 64 random bytes, full throughput
    fr = {};
    for (int i = 0; i < 64; i++) fr.push_back(8'($urandom));
    base = g_dut[0].hs_cnt;
    bad_spacing = 0;
    chk_spacing = 1'b1;
    send_frame(0, fr);
    chk_spacing = 1'b0;
    wait_drain(0);
    check("stream_count", 32'(g_dut[0].hs_cnt - base), 32'd256);
    check("gapless_run", 32'(g_dut[0].run_len), 32'd256);
    check("accept_spacing_bad", 32'(bad_spacing), 32'd0);

    // random backpressure on both widths, 32 bytes each
    rand_rdy = 1'b1;
    fork
      begin
        while (rand_rdy) begin
          @(posedge clk); #1;
          out_ready = 2'($urandom);
        end
      end
    join_none
    fork
      begin
        logic [7:0] f0[$];
        for (int i = 0; i < 32; i++) f0.push_back(8'($urandom));
        send_frame(0, f0);
      end
      begin
        logic [7:0] f1[$];
        for (int i = 0; i < 32; i++) f1.push_back(8'($urandom));
        send_frame(1, f1);
      end
    join
    wait_drain(0);
    wait_drain(1);
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 out_ready = 2'b11;

    // reset after two of four symbols discards the rest
    base = g_dut[0].hs_cnt;
    fr = {8'hB4};
    send_frame(0, fr);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk); #1;
      if (g_dut[0].hs_cnt - base >= 2) seen = 1'b1;
    end
    check("two_before_reset", 32'(g_dut[0].hs_cnt - base), 32'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_valid", 32'(out_valid[0]), 32'd0);
    check("midrst_last", 32'(out_last[0]), 32'd0);
    check("midrst_data", 32'(out_data[0]), 32'd0);
    check("midrst_in_tready", 32'(in_tready[0]), 32'd0);
    exp_q0.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    fr = {8'hFF};
    base = g_dut[0].hs_cnt;
    send_frame(0, fr);
    wait_drain(0);
    check("post_reset_count", 32'(g_dut[0].hs_cnt - base), 32'd4);

    check("leftover0", 32'(exp_q0.size()), 32'd0);
    check("leftover1", 32'(exp_q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
